// File: rtl/mem_arb_pkg.sv
// Shared types and default bus widths for the two-port memory bus arbiter.
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } owner_e;

endpackage

// File: rtl/mem_arb_rr2.sv
// Two-way round-robin pick: a lone request wins; on a tie the port other than last wins.
// Purely combinational, no backpressure of its own.
module mem_arb_rr2 (
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic       gnt_idx_o,
    output logic       gnt_vld_o
);

    assign gnt_vld_o = |req_i;
    assign gnt_idx_o = (&req_i) ? ~last_i : req_i[1];

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory bus between fetch (port 0) and LSU (port 1); grant is combinational, read data one cycle after hit.
// The grant stays locked on its owner until mem_hit or watchdog timeout; the losing port simply waits with req held.
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  r0_req,
    input  logic [ADDR_W-1:0]     r0_addr,
    input  logic [DATA_W-1:0]     r0_wdata,
    input  logic [DATA_W/8-1:0]   r0_be,
    input  logic                  r0_we,
    output logic                  r0_ready,
    output logic                  r0_rvalid,
    output logic [DATA_W-1:0]     r0_rdata,
    output logic                  r0_err,
    input  logic                  r1_req,
    input  logic [ADDR_W-1:0]     r1_addr,
    input  logic [DATA_W-1:0]     r1_wdata,
    input  logic [DATA_W/8-1:0]   r1_be,
    input  logic                  r1_we,
    output logic                  r1_ready,
    output logic                  r1_rvalid,
    output logic [DATA_W-1:0]     r1_rdata,
    output logic                  r1_err,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_be,
    output logic                  mem_we,
    input  logic [DATA_W-1:0]     mem_rdata,
    input  logic                  mem_hit
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    owner_e           owner_q, owner_d;
    logic             rr_last_q, rr_last_d;
    logic             rsp_owner_q, rsp_owner_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

    logic arb_idx, arb_vld;
    logic gnt_vld, gnt_idx;
    logic hit_done, tmo;

    mem_arb_rr2 u_rr (
        .req_i     ({r1_req, r0_req}),
        .last_i    (rr_last_q),
        .gnt_idx_o (arb_idx),
        .gnt_vld_o (arb_vld)
    );

    // Fresh grants are masked while reset is held so the bus and handshakes read as idle.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = 1'b0;
        case (owner_q)
            OWN0:    gnt_vld = 1'b1;
            OWN1: begin
                gnt_vld = 1'b1;
                gnt_idx = 1'b1;
            end
            default: begin
                gnt_vld = arb_vld & rst_n;
                gnt_idx = arb_idx;
            end
        endcase
    end

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = '0;
        mem_we    = 1'b0;
        if (gnt_vld) begin
            if (gnt_idx) begin
                mem_addr  = r1_addr;
                mem_wdata = r1_wdata;
                mem_be    = r1_be;
                mem_we    = r1_we;
            end else begin
                mem_addr  = r0_addr;
                mem_wdata = r0_wdata;
                mem_be    = r0_be;
                mem_we    = r0_we;
            end
        end
    end

    // A hit in the same cycle as the last allowed wait cycle completes normally.
    assign hit_done = gnt_vld & mem_hit;
    assign tmo      = (TIMEOUT > 0) && gnt_vld && !mem_hit && (wait_cnt_q == CNT_LAST);

    assign r0_ready  = hit_done & ~gnt_idx;
    assign r1_ready  = hit_done &  gnt_idx;
    assign r0_err    = tmo & ~gnt_idx;
    assign r1_err    = tmo &  gnt_idx;
    assign r0_rvalid = rsp_valid_q & ~rsp_owner_q;
    assign r1_rvalid = rsp_valid_q &  rsp_owner_q;
    assign r0_rdata  = r0_rvalid ? mem_rdata : '0;
    assign r1_rdata  = r1_rvalid ? mem_rdata : '0;

    always_comb begin
        owner_d     = owner_q;
        rr_last_d   = rr_last_q;
        rsp_owner_d = rsp_owner_q;
        rsp_valid_d = 1'b0;
        wait_cnt_d  = '0;
        if (hit_done) begin
            owner_d   = IDLE;
            rr_last_d = gnt_idx;
            if (!mem_we) begin
                rsp_valid_d = 1'b1;
                rsp_owner_d = gnt_idx;
            end
        end else if (tmo) begin
            owner_d   = IDLE;
            rr_last_d = gnt_idx;
        end else if (gnt_vld) begin
            owner_d = gnt_idx ? OWN1 : OWN0;
            if (TIMEOUT > 0) begin
                wait_cnt_d = wait_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q     <= IDLE;
            rr_last_q   <= 1'b1;
            rsp_owner_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            wait_cnt_q  <= '0;
        end else begin
            owner_q     <= owner_d;
            rr_last_q   <= rr_last_d;
            rsp_owner_q <= rsp_owner_d;
            rsp_valid_q <= rsp_valid_d;
            wait_cnt_q  <= wait_cnt_d;
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: a TIMEOUT=64 instance for the main traffic and a
// TIMEOUT=4 instance sharing the same stimulus for the watchdog case.
module tb_mem_bus_arbiter;
    import mem_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        r0_req, r0_we, r1_req, r1_we, mem_hit;
    logic [31:0] r0_addr, r0_wdata, r1_addr, r1_wdata, mem_rdata;
    logic [3:0]  r0_be, r1_be;

    logic        r0_ready, r0_rvalid, r0_err, r1_ready, r1_rvalid, r1_err, mem_we;
    logic [31:0] r0_rdata, r1_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_be;

    logic        t_r0_ready, t_r0_rvalid, t_r0_err, t_r1_ready, t_r1_rvalid, t_r1_err, t_mem_we;
    logic [31:0] t_r0_rdata, t_r1_rdata, t_mem_addr, t_mem_wdata;
    logic [3:0]  t_mem_be;

    int n_chk  = 0;
    int n_fail = 0;
    bit tmo_phase = 1'b0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .r0_req(r0_req), .r0_addr(r0_addr), .r0_wdata(r0_wdata), .r0_be(r0_be), .r0_we(r0_we),
        .r0_ready(r0_ready), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata), .r0_err(r0_err),
        .r1_req(r1_req), .r1_addr(r1_addr), .r1_wdata(r1_wdata), .r1_be(r1_be), .r1_we(r1_we),
        .r1_ready(r1_ready), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata), .r1_err(r1_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .mem_hit(mem_hit)
    );

    mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut_to (
        .clk(clk), .rst_n(rst_n),
        .r0_req(r0_req), .r0_addr(r0_addr), .r0_wdata(r0_wdata), .r0_be(r0_be), .r0_we(r0_we),
        .r0_ready(t_r0_ready), .r0_rvalid(t_r0_rvalid), .r0_rdata(t_r0_rdata), .r0_err(t_r0_err),
        .r1_req(r1_req), .r1_addr(r1_addr), .r1_wdata(r1_wdata), .r1_be(r1_be), .r1_we(r1_we),
        .r1_ready(t_r1_ready), .r1_rvalid(t_r1_rvalid), .r1_rdata(t_r1_rdata), .r1_err(t_r1_err),
        .mem_addr(t_mem_addr), .mem_wdata(t_mem_wdata), .mem_be(t_mem_be), .mem_we(t_mem_we),
        .mem_rdata(mem_rdata), .mem_hit(mem_hit)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        r0_req = 1'b0; r0_addr = '0; r0_wdata = '0; r0_be = '0; r0_we = 1'b0;
        r1_req = 1'b0; r1_addr = '0; r1_wdata = '0; r1_be = '0; r1_we = 1'b0;
        mem_hit = 1'b0; mem_rdata = '0;
    endtask

    // Let combinational outputs settle mid-cycle, then confirm the stimulus keeps owned requests held.
    task automatic settle();
        #2;
        if (rst_n && !tmo_phase) begin
            if (dut.owner_q == OWN0) check("proto_r0_hold", r0_req, 1'b1);
            if (dut.owner_q == OWN1) check("proto_r1_hold", r1_req, 1'b1);
        end
        if (rst_n && tmo_phase) begin
            if (dut_to.owner_q == OWN0) check("proto_t_r0_hold", r0_req, 1'b1);
            if (dut_to.owner_q == OWN1) check("proto_t_r1_hold", r1_req, 1'b1);
        end
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        r0_req = 1'b1; r0_we = 1'b1; r0_be = 4'hF; r0_addr = 32'h44; mem_hit = 1'b1;
        #2;
        check("rst_mem_we", mem_we, 1'b0);
        check("rst_mem_be", mem_be, 4'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_r0_ready", r0_ready, 1'b0);
        check("rst_r0_rvalid", r0_rvalid, 1'b0);
        check("rst_r0_rdata", r0_rdata, 32'h0);
        check("rst_r0_err", r0_err, 1'b0);
        check("rst_r1_ready", r1_ready, 1'b0);
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;

        // Contention: grants alternate 0,1,0,1,0; rvalid follows each ready by one cycle.
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            r0_req = (k < 5); r0_addr = 32'h200;
            r1_req = (k < 4); r1_addr = 32'h300;
            mem_hit = (k < 5);
            mem_rdata = 32'hA000_0000 + k;
            settle();
            if (k < 5) check("ctn_addr", mem_addr, (k % 2 == 1) ? 32'h300 : 32'h200);
            check("ctn_r0_ready", r0_ready, (k < 5) && (k % 2 == 0));
            check("ctn_r1_ready", r1_ready, (k < 5) && (k % 2 == 1));
            if (k > 0) begin
                check("ctn_r0_rvalid", r0_rvalid, (k % 2 == 1));
                check("ctn_r1_rvalid", r1_rvalid, (k % 2 == 0));
                check("ctn_rdata", (k % 2 == 1) ? r0_rdata : r1_rdata, 32'hA000_0000 + k);
                check("ctn_other_rdata", (k % 2 == 1) ? r1_rdata : r0_rdata, 32'h0);
            end
        end

        // Single read with immediate hit.
        @(negedge clk);
        r0_req = 1'b1; r0_addr = 32'h100; r0_we = 1'b0; r0_be = 4'hF; mem_hit = 1'b1;
        settle();
        check("sr_addr", mem_addr, 32'h100);
        check("sr_r0_ready", r0_ready, 1'b1);
        check("sr_mem_we", mem_we, 1'b0);
        check("sr_r1_ready", r1_ready, 1'b0);
        @(negedge clk);
        r0_req = 1'b0; mem_hit = 1'b0; mem_rdata = 32'hDEAD_BEEF;
        settle();
        check("sr_r0_rvalid", r0_rvalid, 1'b1);
        check("sr_r0_rdata", r0_rdata, 32'hDEAD_BEEF);
        check("sr_r1_rvalid", r1_rvalid, 1'b0);
        check("sr_r1_rdata", r1_rdata, 32'h0);
        check("sr_idle_addr", mem_addr, 32'h0);
        check("sr_idle_be", mem_be, 4'h0);

        // Write from port 1.
        @(negedge clk);
        r1_req = 1'b1; r1_we = 1'b1; r1_be = 4'b0011; r1_wdata = 32'h1234; r1_addr = 32'h400; mem_hit = 1'b1;
        settle();
        check("wr_mem_we", mem_we, 1'b1);
        check("wr_mem_be", mem_be, 4'b0011);
        check("wr_mem_wdata", mem_wdata, 32'h1234);
        check("wr_mem_addr", mem_addr, 32'h400);
        check("wr_r1_ready", r1_ready, 1'b1);
        check("wr_r0_ready", r0_ready, 1'b0);
        @(negedge clk);
        r1_req = 1'b0; r1_we = 1'b0; mem_hit = 1'b0;
        settle();
        check("wr_r1_rvalid", r1_rvalid, 1'b0);
        check("wr_r0_rvalid", r0_rvalid, 1'b0);

        // Stall lock: r0 holds the bus for 6 cycles while r1 waits, then r1 gets it.
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            r0_req = (c <= 6); r0_addr = 32'h500; r0_we = 1'b0;
            r1_req = (c <= 7); r1_addr = 32'h600; r1_we = 1'b0;
            mem_hit = (c >= 6) && (c <= 7);
            mem_rdata = 32'hB000_0000 + c;
            settle();
            if (c <= 6) check("stall_addr", mem_addr, 32'h500);
            check("stall_r0_ready", r0_ready, c == 6);
            check("stall_r1_ready", r1_ready, c == 7);
            check("stall_r0_err", r0_err, 1'b0);
            if (c == 7) begin
                check("stall_r1_addr", mem_addr, 32'h600);
                check("stall_r0_rvalid", r0_rvalid, 1'b1);
                check("stall_r0_rdata", r0_rdata, 32'hB000_0007);
            end
            if (c == 8) begin
                check("stall_r1_rvalid", r1_rvalid, 1'b1);
                check("stall_r1_rdata", r1_rdata, 32'hB000_0008);
                check("stall_r0_rvalid_end", r0_rvalid, 1'b0);
            end
        end

        // Reset asserted mid-cycle while port 1 owns the bus.
        @(negedge clk);
        r1_req = 1'b1; r1_addr = 32'h700; r1_we = 1'b1; r1_be = 4'hC; r1_wdata = 32'h55; mem_hit = 1'b0;
        settle();
        check("rs_grant_addr", mem_addr, 32'h700);
        @(negedge clk);
        settle();
        check("rs_owned_be", mem_be, 4'hC);
        mem_hit = 1'b1;
        rst_n = 1'b0;
        #1;
        check("rs_mem_addr", mem_addr, 32'h0);
        check("rs_mem_we", mem_we, 1'b0);
        check("rs_mem_be", mem_be, 4'h0);
        check("rs_mem_wdata", mem_wdata, 32'h0);
        check("rs_r1_ready", r1_ready, 1'b0);
        check("rs_r1_err", r1_err, 1'b0);
        check("rs_r1_rvalid", r1_rvalid, 1'b0);
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        r0_req = 1'b1; r0_addr = 32'h800; r0_we = 1'b0;
        r1_req = 1'b1; r1_addr = 32'h900; r1_we = 1'b0;
        mem_hit = 1'b1;
        settle();
        check("rs_tie_addr", mem_addr, 32'h800);
        check("rs_tie_r0_ready", r0_ready, 1'b1);
        check("rs_tie_r1_ready", r1_ready, 1'b0);
        @(negedge clk);
        r0_req = 1'b0;
        settle();
        check("rs_next_r1_ready", r1_ready, 1'b1);
        check("rs_next_r0_rvalid", r0_rvalid, 1'b1);

        // Watchdog on the TIMEOUT=4 instance: err on the 4th granted cycle, then r1 is served.
        tmo_phase = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            r0_req = (c <= 4); r0_addr = 32'hA00; r0_we = 1'b0;
            r1_req = (c <= 5); r1_addr = 32'hB00; r1_we = 1'b0;
            mem_hit = (c == 5);
            mem_rdata = 32'hC000_0000 + c;
            settle();
            if (c <= 4) check("to_addr", t_mem_addr, 32'hA00);
            check("to_r0_err", t_r0_err, c == 4);
            check("to_r0_ready", t_r0_ready, 1'b0);
            check("to_r0_rvalid", t_r0_rvalid, 1'b0);
            check("to_r1_err", t_r1_err, 1'b0);
            if (c == 5) begin
                check("to_r1_addr", t_mem_addr, 32'hB00);
                check("to_r1_ready", t_r1_ready, 1'b1);
            end
            if (c == 6) check("to_r1_rvalid", t_r1_rvalid, 1'b1);
        end

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
Shares one synchronous memory bus between two requesters: port 0 (instruction fetch) and port 1 (load/store unit). The bus carries addr, data_i, data_o, data_en, write_en and hit, where hit means "data for the current address is valid next cycle". The block grants the bus round-robin, holds the grant until the memory signals hit, and routes read data back to the winner one cycle later. It sits between the core's two memory masters and the memory/bus module.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width; byte enables are DATA_W/8 bits
TIMEOUT, 64, maximum cycles a granted access may wait for hit before it is aborted; 0 disables the watchdog

Ports:
clk  in  1  clock; all state updates on the rising edge
rst_n  in  1  asynchronous active-low reset
rN_req  in  1  requester N access request; N = 0, 1 (repeat for each port below)
rN_addr  in  ADDR_W  requester N address
rN_wdata  in  DATA_W  requester N write data
rN_be  in  DATA_W/8  requester N byte enables
rN_we  in  1  requester N write enable
rN_ready  out  1  access accepted and completed this cycle
rN_rvalid  out  1  rN_rdata valid this cycle
rN_rdata  out  DATA_W  read data
rN_err  out  1  access aborted by timeout
mem_addr  out  ADDR_W  to bus addr
mem_wdata  out  DATA_W  to bus data_i
mem_be  out  DATA_W/8  to bus data_en
mem_we  out  1  to bus write_en
mem_rdata  in  DATA_W  from bus data_o
mem_hit  in  1  from bus hit

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- State: owner_q is one of IDLE, OWN0, OWN1. Also rr_last_q (last-granted port), rsp_owner_q, rsp_valid_q and wait_cnt_q.
- Reset values:
  - owner_q = IDLE; rr_last_q = 1, so port 0 wins the first tie; rsp_valid_q = 0; wait_cnt_q = 0.
  - All rN_ready, rN_rvalid and rN_err are 0. rN_rdata is 0.
  - mem_we = 0 and mem_be = 0.
- Arbitration in IDLE (combinational, zero added latency):
  - If only one request is high, that port wins.
  - If both are high, the port other than rr_last_q wins.
  - The winner's addr, wdata, be and we drive the mem_* outputs in the same cycle.
- Arbitration in OWN0 or OWN1: the owner's payload drives mem_* and the other port is ignored.
- No requester (IDLE and no req): mem_we = 0, mem_be = 0, mem_addr = 0, mem_wdata = 0.
- Completion: mem_hit while a port is granted (IDLE winner or owner):
  - rN_ready = 1 combinationally for that port.
  - rr_last_q takes that port; owner_q goes to IDLE.
  - For a read (we = 0), the response is scheduled: rsp_owner_q = port and rsp_valid_q = 1 for exactly the next cycle.
- Stall: a granted access without mem_hit sets owner_q to that port. The grant stays locked until hit or timeout.
- Requester rule: req and payload are held stable from the first cycle of req until rN_ready or rN_err. Dropping req while owned is a protocol violation; the bench asserts it never happens.
- Read response: in the cycle after the completing hit, r[rsp_owner_q]_rvalid = 1 and r[rsp_owner_q]_rdata = mem_rdata. The other port sees rvalid = 0 and rdata = 0.
- Back-to-back: a new grant may issue in the same cycle that a previous read's rvalid is high. Full throughput is one access per cycle when the memory hits every cycle.
- Writes: completion at rN_ready. No rvalid is generated.
- Watchdog: wait_cnt_q counts consecutive granted no-hit cycles and clears on hit or when a grant starts.
  - If TIMEOUT > 0 and the counter reaches TIMEOUT-1 with no hit, rN_err = 1 for one cycle (no ready) and the access is dropped.
  - On timeout: owner_q goes to IDLE, rr_last_q takes that port, and no rvalid is generated.
- Simultaneous events: rvalid of access K and ready of access K+1 in the same cycle are both honoured. Hit and timeout in the same cycle: hit wins.
- Reset mid-operation: all state returns to reset values immediately. An in-flight access is lost and no rvalid or err is produced.
- Widths: the counter is $clog2(TIMEOUT+1) bits. For TIMEOUT = 0 the counter is unused.

Decomposition:
- Package mem_arb_pkg: owner_e enum (IDLE, OWN0, OWN1) and the default ADDR_W/DATA_W constants.
- One sub-module, mem_arb_rr2: the 2-way round-robin pick (inputs req[1:0] and last; output grant index and valid).
- Muxing, the watchdog and response routing stay in the top level.

Test Plan:
- Single read: r0_req, addr 0x100, we = 0, mem_hit = 1 immediately -> r0_ready same cycle. Next cycle r0_rvalid = 1 and r0_rdata = mem_rdata (0xDEADBEEF). r1 outputs stay 0.
- Contention: r0 and r1 request every cycle with mem_hit = 1 -> grants alternate 0,1,0,1 starting with 0. Each rvalid lands on the correct port one cycle after its ready.
- Stall lock: r0 granted with mem_hit = 0 for 5 cycles while r1 requests -> mem_addr stays at r0's address for all 6 cycles. r0_ready occurs on cycle 6. r1 is granted on cycle 7.
- Write: r1 we = 1, be = 4'b0011, wdata = 0x1234 -> mem_we = 1, mem_be = 0011, mem_wdata = 0x1234. r1_ready on hit. No r1_rvalid.
- Timeout: TIMEOUT = 4 with mem_hit held 0 -> r0_err pulses on the 4th granted cycle. Next cycle the arbiter is IDLE and r1 is granted. No rvalid appears.
- Reset mid-stall: rst_n asserted while owner = OWN1 -> all outputs 0 asynchronously. After release, r0 wins the first tie.
